mod_counter: RTL and testbench

- Parametrised successor to the team's fixed 6-bit up-counter: WIDTH-bit up/down counter with a runtime modulus, synchronous load, count enable, built-in prescaler and a registered terminal-count pulse.
- Drives timebases in the drive-sim FPGA fabric, such as frame, PWM and sample ticks.
- Any instance can be cascaded through tc into another instance's en.

---
 rtl/mod_counter_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 45 ++++
 rtl/mod_counter.sv | 87 ++++++++
 tb/tb_mod_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulus counter: direction encoding, width
// limits and a constant-evaluable log2 helper used to size the prescaler.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAX_WIDTH = 32;

  // Smallest r such that 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler for mod_counter: emits step on every PRESCALE-th enabled cycle.
// sync_clr restarts the division so a fresh period begins on the next cycle.
module tick_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic clr,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  // At least one bit even when PRESCALE=1 (the counter then never leaves 0).
  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign step = en && (pre_q == LAST);

  // Next prescaler value: clear on load, wrap on step, advance when enabled.
  always_comb begin
    pre_d = pre_q;
    if (sync_clr) begin
      pre_d = '0;
    end else if (step) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Prescaler state register with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// WIDTH-bit up/down counter with runtime modulus (0..limit), synchronous load,
// prescaled enable and a registered terminal-count pulse.
// Optional build macro MOD_COUNTER_SATURATE_EN: boundary steps hold at the
// range end instead of wrapping (tc still pulses on every boundary step).
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             step;

  // A load restarts the prescale period so the next step is a full period away.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock    (clock),
    .clr      (clr),
    .en       (en),
    .sync_clr (load),
    .step     (step)
  );

  // Next count/tc: load beats step beats hold; limit is only consulted on a step.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      if (up == DIR_UP) begin
        // Values above limit (e.g. after an unclipped load) also wrap here.
        if (count_q >= limit) begin
          tc_d = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
          count_d = limit;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
`ifdef MOD_COUNTER_SATURATE_EN
          count_d = '0;
`else
          count_d = limit;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and terminal-count registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: two instances (PRESCALE=1 and 4) share one
// stimulus stream; a reference model pushes expected count/tc per edge and a
// monitor pops and compares on the falling edge.
module tb_mod_counter;

  localparam int W = 6;
  localparam int M = 1 << W;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] cnt0, cnt1;
  logic         tc0, tc1;

  int checks = 0;
  int failures = 0;

  // Reference state per instance (index 0: PRESCALE=1, index 1: PRESCALE=4).
  int m_cnt[2];
  int m_pre[2];
  bit m_tc[2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(W), .PRESCALE(1)) dut0 (
    .clock(clk), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .count(cnt0), .tc(tc0)
  );

  mod_counter #(.WIDTH(W), .PRESCALE(4)) dut1 (
    .clock(clk), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .count(cnt1), .tc(tc1)
  );

  function automatic int prescale_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit saturating();
`ifdef MOD_COUNTER_SATURATE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_pre[i] = 0;
      m_tc[i]  = 1'b0;
    end
  endtask

  // Apply the behavioural rules for one rising edge to instance i.
  task automatic model_edge(input int i);
    int lim;
    lim = int'(limit);
    if (!clr) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 1'b0;
    end else if (load) begin
      m_cnt[i] = int'(load_val); m_pre[i] = 0; m_tc[i] = 1'b0;
    end else begin
      m_tc[i] = 1'b0;
      if (en) begin
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == prescale_of(i)) begin
          m_pre[i] = 0;
          if (up) begin
            if (m_cnt[i] >= lim) begin
              m_cnt[i] = saturating() ? lim : 0;
              m_tc[i]  = 1'b1;
            end else begin
              m_cnt[i] = (m_cnt[i] + 1) % M;
            end
          end else begin
            if (m_cnt[i] == 0) begin
              m_cnt[i] = saturating() ? 0 : lim;
              m_tc[i]  = 1'b1;
            end else begin
              m_cnt[i] = m_cnt[i] - 1;
            end
          end
        end
      end
    end
  endtask

  // One clock: model the edge, push expectations, then release for new inputs.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    e.cnt = W'(m_cnt[0]); e.tc = m_tc[0]; q0.push_back(e);
    e.cnt = W'(m_cnt[1]); e.tc = m_tc[1]; q1.push_back(e);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Drop clr between edges and confirm the outputs clear before the next edge.
  task automatic async_reset(input int hold_edges);
    @(negedge clk);
    #2;
    clr = 1'b0;
    model_reset();
    #1;
    check("async_cnt0", int'(cnt0), 0);
    check("async_tc0", int'(tc0), 0);
    check("async_cnt1", int'(cnt1), 0);
    check("async_tc1", int'(tc1), 0);
    $display("async reset applied t=%0t", $time);
    for (int k = 0; k < hold_edges; k++) cycle();
    clr = 1'b1;
  endtask

  // Monitor: compare each instance against its next expected value.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("cnt_p1", int'(cnt0), int'(e.cnt));
        check("tc_p1", int'(tc0), int'(e.tc));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("cnt_p4", int'(cnt1), int'(e.cnt));
        check("tc_p4", int'(tc1), int'(e.tc));
        $display("txn cnt0=%0d tc0=%0d cnt1=%0d tc1=%0d", cnt0, tc0, cnt1, tc1);
      end
    end
  end

  initial begin
    bit pat[5];
    model_reset();
    // Reset state while clr is low.
    cycle(); cycle();
    #1;
    check("reset_cnt", int'(cnt0), 0);
    check("reset_tc", int'(tc0), 0);

    // Full-range up count: 64 steps wraps to 0 with tc.
    limit = 6'd63; up = 1'b1; en = 1'b1; clr = 1'b1;
    for (int k = 0; k < 66; k++) cycle();

    // Down count with limit=9 from reset.
    async_reset(1);
    limit = 6'd9; up = 1'b0;
    for (int k = 0; k < 24; k++) cycle();

    // Load above limit while counting up, then >= limit wrap.
    async_reset(1);
    limit = 6'd40; up = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    load = 1'b1; load_val = 6'd50; cycle();
    load = 1'b0;
    for (int k = 0; k < 6; k++) cycle();

    // Prescaler with gapped enable, then load clears the prescaler.
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 5; k++) begin en = pat[k]; cycle(); end
    en = 1'b1; cycle(); cycle();
    load = 1'b1; load_val = 6'd3; cycle();
    load = 1'b0;
    for (int k = 0; k < 6; k++) cycle();

    // limit=0 in both directions.
    limit = 6'd0; up = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    up = 1'b0;
    for (int k = 0; k < 6; k++) cycle();

    // Mid-cycle asynchronous reset held over three edges.
    limit = 6'd63; up = 1'b1;
    for (int k = 0; k < 37; k++) cycle();
    async_reset(3);
    for (int k = 0; k < 5; k++) cycle();

    // Small limit in both directions (saturation region when enabled).
    limit = 6'd5; up = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    up = 1'b0;
    for (int k = 0; k < 10; k++) cycle();

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) up = ~up;
      load = ($urandom_range(0, 24) == 0);
      load_val = W'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: limit = '0;
          1: limit = '1;
          default: limit = W'($urandom);
        endcase
      end
      if ($urandom_range(0, 299) == 0) async_reset($urandom_range(0, 2));
      else cycle();
    end

    // Drain and confirm every expectation was consumed.
    load = 1'b0; en = 1'b0;
    @(negedge clk); @(negedge clk);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
